// File: rtl/maxpool_stream_unit.sv
// rtl/maxpool_stream_unit.sv - streaming 2x2 max-pool (stride 2 / stride 1 replicate / bypass)
// One line buffer plus two window registers form the 2x2 window around each accepted pixel.
module maxpool_stream_unit #(
   parameter int LANES      = 16,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_WIDTH  = 32,
   parameter int WIDTH_BITS = $clog2(MAX_WIDTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [1:0]                  cfg_mode,
   input  logic [WIDTH_BITS-1:0]       cfg_width,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic                        busy,
   output logic                        done
);
   localparam int PW = LANES * DATA_WIDTH;
   localparam int AW = $clog2(MAX_WIDTH);
   localparam logic [WIDTH_BITS-1:0] MAXW = WIDTH_BITS'(MAX_WIDTH);
   localparam logic [1:0] M_BYP = 2'd0, M_S2 = 2'd1, M_S1 = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

   state_t                state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [WIDTH_BITS-1:0] width_q, width_d, r_q, r_d, c_q, c_d;
   logic                  bubble_q, bubble_d, busy_q, busy_d, done_q, done_d;
   logic                  out_valid_q, out_valid_d;
   logic [PW-1:0]         out_data_q, out_data_d, prev_q, prev_d, up_prev_q, up_prev_d;
   logic [PW-1:0]         lb_q [MAX_WIDTH];
   logic                  lb_we;

   logic                  width_ok, last_col, last_row, slot_free, accept;
   logic [WIDTH_BITS-1:0] c_nx;
   logic [PW-1:0]         lb_rd, lb_rd_nx, window;

   function automatic logic [PW-1:0] vmax(input logic [PW-1:0] a, input logic [PW-1:0] b);
      logic [PW-1:0] m;
      m = '0;
      for (int k = 0; k < LANES; k++) begin
         if ($signed(a[k*DATA_WIDTH +: DATA_WIDTH]) > $signed(b[k*DATA_WIDTH +: DATA_WIDTH]))
            m[k*DATA_WIDTH +: DATA_WIDTH] = a[k*DATA_WIDTH +: DATA_WIDTH];
         else
            m[k*DATA_WIDTH +: DATA_WIDTH] = b[k*DATA_WIDTH +: DATA_WIDTH];
      end
      return m;
   endfunction

   assign width_ok  = (width_q >= WIDTH_BITS'(2)) && (width_q <= MAXW);
   assign last_col  = (c_q == width_q - 1'b1);
   assign last_row  = (r_q == width_q - 1'b1);
   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = (state_q == S_RUN) && width_ok && !bubble_q && slot_free;
   assign accept    = in_valid && in_ready;
   assign c_nx      = last_col ? c_q : c_q + 1'b1;
   assign lb_rd     = lb_q[c_q[AW-1:0]];
   assign lb_rd_nx  = lb_q[c_nx[AW-1:0]];
   // up_prev = p[r-1][c-1], lb[c] = p[r-1][c], prev = p[r][c-1], in_data = p[r][c]
   assign window    = vmax(vmax(up_prev_q, lb_rd), vmax(prev_q, in_data));

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      width_d     = width_q;
      r_d         = r_q;
      c_d         = c_q;
      bubble_d    = bubble_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      prev_d      = prev_q;
      up_prev_d   = up_prev_q;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      lb_we       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d   = (cfg_mode == 2'd3) ? M_BYP : cfg_mode;
               width_d  = cfg_width;
               r_d      = '0;
               c_d      = '0;
               bubble_d = 1'b0;
               busy_d   = 1'b1;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (!width_ok) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (bubble_q) begin
               // right-edge replication: out(r-1,W-1) only sees the last column of two rows
               if (slot_free) begin
                  out_valid_d = 1'b1;
                  out_data_d  = vmax(up_prev_q, prev_q);
                  bubble_d    = 1'b0;
                  if (r_q == width_q) state_d = S_DRAIN;
               end
            end else if (accept) begin
               lb_we     = 1'b1;
               prev_d    = in_data;
               up_prev_d = lb_rd;
               c_d       = last_col ? '0 : c_q + 1'b1;
               r_d       = last_col ? r_q + 1'b1 : r_q;
               case (mode_q)
                  M_S2: begin
                     if (r_q[0] && c_q[0]) begin
                        out_valid_d = 1'b1;
                        out_data_d  = window;
                     end
                  end
                  M_S1: begin
                     if ((r_q != '0) && (c_q != '0)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = window;
                     end
                     if (last_col && (r_q != '0)) bubble_d = 1'b1;
                  end
                  default: begin
                     out_valid_d = 1'b1;
                     out_data_d  = in_data;
                  end
               endcase
               if (last_col && last_row && (mode_q != M_S1)) state_d = S_FINISH;
            end
         end
         S_DRAIN: begin
            // bottom-edge replication: last row pooled with itself, column clamped at W-1
            if (slot_free) begin
               out_valid_d = 1'b1;
               out_data_d  = vmax(lb_rd, lb_rd_nx);
               if (last_col) state_d = S_FINISH;
               else          c_d     = c_q + 1'b1;
            end
         end
         default: begin
            if (slot_free) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mode_q      <= M_BYP;
         width_q     <= '0;
         r_q         <= '0;
         c_q         <= '0;
         bubble_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         prev_q      <= '0;
         up_prev_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         width_q     <= width_d;
         r_q         <= r_d;
         c_q         <= c_d;
         bubble_q    <= bubble_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         prev_q      <= prev_d;
         up_prev_q   <= up_prev_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // row 0 never consumes line-buffer reads, so the buffer needs no reset
   always_ff @(posedge clk) begin
      if (lb_we) lb_q[c_q[AW-1:0]] <= in_data;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_maxpool_stream_unit.sv
// tb/tb_maxpool_stream_unit.sv - directed self-checking bench for maxpool_stream_unit
module tb_maxpool_stream_unit;
   localparam int LN = 16, DW = 16, MW = 32, WB = 6, PW = LN * DW;

   logic          clk, rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, done;
   logic [1:0]    cfg_mode;
   logic [WB-1:0] cfg_width;
   logic [PW-1:0] in_data, out_data;

   maxpool_stream_unit #(.LANES(LN), .DATA_WIDTH(DW), .MAX_WIDTH(MW), .WIDTH_BITS(WB)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_width(cfg_width),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done));

   typedef struct { int frame; int idx; int lane; int expv; } vec_t;

   int            n_cmp = 0, n_bad = 0;
   int            cyc = 0, s_cyc = 0, done_cyc = 0, done_cnt = 0, acc = 0, hold_cycles = 0;
   int            block_cnt = 0;
   bit            rdy_rand = 0, hold_q = 0;
   logic [PW-1:0] hold_data;
   logic [PW-1:0] src[$], got[$], exp_q[$];
   int            low_at[$];
   vec_t          tbl[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (block_cnt > 0) begin
            out_ready = 1'b0;
            block_cnt--;
         end else if (rdy_rand) out_ready = ($urandom_range(0, 1) == 1);
         else out_ready = 1'b1;
      end
   end

   task automatic chk(input string name, input longint act, input longint expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_q) begin
            n_cmp++;
            if (!out_valid || out_data !== hold_data) begin
               n_bad++;
               $display("FAIL hold_stable: out_valid=%0b data=%h, required valid=1 data=%h",
                        out_valid, out_data[31:0], hold_data[31:0]);
            end
         end
         if (out_valid && !out_ready) begin
            hold_cycles++;
            chk("inready_blocked", in_ready, 0);
         end
         if (busy && !in_ready) low_at.push_back(acc);
         if (in_valid && in_ready) acc++;
         if (out_valid && out_ready) got.push_back(out_data);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         hold_q    = out_valid && !out_ready;
         hold_data = out_data;
      end else hold_q = 0;
   end

   function automatic int lane_of(input logic [PW-1:0] v, input int k);
      return int'($signed(v[k*DW +: DW]));
   endfunction

   task automatic make_src(input int kind, input int w);
      logic [PW-1:0] v;
      src.delete();
      for (int n = 0; n < w * w; n++) begin
         v = '0;
         for (int k = 0; k < LN; k++) begin
            if (kind == 0) begin
               if (k == 0) v[k*DW +: DW] = 16'(n);
               if (k == 1) v[k*DW +: DW] = 16'(-n);
            end else if (kind == 1) v[k*DW +: DW] = 16'($urandom);
            else v[k*DW +: DW] = -16'sd128;
         end
         src.push_back(v);
      end
   endtask

   function automatic logic [PW-1:0] win(input int w, input int r0, input int c0, input int r1, input int c1);
      logic [PW-1:0] m;
      int            a, b, c, d, x;
      m = '0;
      for (int k = 0; k < LN; k++) begin
         a = lane_of(src[r0*w + c0], k);
         b = lane_of(src[r0*w + c1], k);
         c = lane_of(src[r1*w + c0], k);
         d = lane_of(src[r1*w + c1], k);
         x = a;
         if (b > x) x = b;
         if (c > x) x = c;
         if (d > x) x = d;
         m[k*DW +: DW] = 16'(x);
      end
      return m;
   endfunction

   task automatic build_exp(input int mode, input int w);
      exp_q.delete();
      if (w < 2 || w > MW) return;
      if (mode == 1) begin
         for (int i = 0; i < w / 2; i++)
            for (int j = 0; j < w / 2; j++)
               exp_q.push_back(win(w, 2*i, 2*j, 2*i + 1, 2*j + 1));
      end else if (mode == 2) begin
         for (int i = 0; i < w; i++)
            for (int j = 0; j < w; j++)
               exp_q.push_back(win(w, i, j, (i + 1 < w) ? i + 1 : w - 1, (j + 1 < w) ? j + 1 : w - 1));
      end else begin
         for (int n = 0; n < w * w; n++) exp_q.push_back(src[n]);
      end
   endtask

   task automatic check_stream(input string name);
      int first = -1;
      n_cmp++;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         if (first < 0 && got[i] !== exp_q[i]) first = i;
      if (got.size() != exp_q.size() || first >= 0) begin
         n_bad++;
         $display("FAIL %s: %0d outputs, first differing index %0d; required %0d outputs equal to model",
                  name, got.size(), first, exp_q.size());
      end
   endtask

   task automatic start_frame(input logic [1:0] mode, input int w);
      @(posedge clk);
      #1;
      got.delete();
      low_at.delete();
      done_cnt  = 0;
      acc       = 0;
      cfg_mode  = mode;
      cfg_width = WB'(w);
      start     = 1'b1;
      s_cyc     = cyc;
      @(posedge clk);
      #1;
      start     = 1'b0;
      cfg_mode  = 2'd2;
      cfg_width = WB'(7);
   endtask

   task automatic feed(input int from, input int to);
      int idx = from;
      int n   = 0;
      while (idx < to && n < 5000) begin
         in_valid = 1'b1;
         in_data  = src[idx];
         @(negedge clk);
         if (in_ready) idx++;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (idx < to) chk("feed_timeout", idx, to);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_table(input int frame, input string name);
      int act;
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].frame == frame) begin
            act = (tbl[i].idx < got.size()) ? lane_of(got[tbl[i].idx], tbl[i].lane) : 32'h7fffffff;
            chk($sformatf("%s_out%0d_lane%0d", name, tbl[i].idx, tbl[i].lane), act, tbl[i].expv);
         end
      end
   endtask

   initial begin
      int s2_l0[4]  = '{5, 7, 13, 15};
      int s2_l1[4]  = '{0, -2, -8, -10};
      int s1_l0[9]  = '{4, 5, 5, 7, 8, 8, 7, 8, 8};
      int gap_e[6]  = '{6, 9, 9, 9, 9, 9};
      int bad_w[2]  = '{1, 40};
      vec_t v;
      for (int i = 0; i < 4; i++) begin
         v = '{0, i, 0, s2_l0[i]}; tbl.push_back(v);
         v = '{0, i, 1, s2_l1[i]}; tbl.push_back(v);
      end
      for (int i = 0; i < 9; i++) begin
         v = '{1, i, 0, s1_l0[i]}; tbl.push_back(v);
      end

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      cfg_mode = 2'd0; cfg_width = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data_nonzero", (out_data != '0) ? 1 : 0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 0);

      // stride 2, W=4, ramp pattern
      make_src(0, 4);
      start_frame(2'd1, 4);
      @(negedge clk);
      chk("busy_after_start", busy, 1);
      chk("in_ready_after_start", in_ready, 1);
      @(posedge clk);
      #1;
      feed(0, 16);
      wait_done(200);
      apply_table(0, "s2w4");
      chk("s2w4_count", got.size(), 4);
      chk("s2w4_done_once", done_cnt, 1);

      // stride 1, W=3, ramp pattern with bubbles and drain
      make_src(0, 3);
      start_frame(2'd2, 3);
      feed(0, 9);
      wait_done(200);
      apply_table(1, "s1w3");
      build_exp(2, 3);
      check_stream("s1w3_stream");
      chk("s1w3_gap_count", low_at.size(), 6);
      for (int i = 0; i < low_at.size() && i < 6; i++)
         chk($sformatf("s1w3_gap%0d_after_pixels", i), low_at[i], gap_e[i]);
      chk("s1w3_done_once", done_cnt, 1);

      // bypass, W=13, random data, random out_ready
      make_src(1, 13);
      rdy_rand = 1;
      start_frame(2'd0, 13);
      feed(0, 169);
      wait_done(3000);
      rdy_rand = 0;
      build_exp(0, 13);
      check_stream("byp_w13_stream");
      chk("byp_w13_count", got.size(), 169);
      chk("byp_w13_done_once", done_cnt, 1);

      // reserved mode behaves as bypass
      make_src(1, 2);
      start_frame(2'd3, 2);
      feed(0, 4);
      wait_done(200);
      build_exp(0, 2);
      check_stream("mode3_bypass_stream");

      // stride 2, W=26 with a 10-cycle output stall mid-row
      make_src(1, 26);
      hold_cycles = 0;
      start_frame(2'd1, 26);
      feed(0, 140);
      block_cnt = 10;
      feed(140, 676);
      wait_done(3000);
      build_exp(1, 26);
      check_stream("bp_s2w26_stream");
      chk("bp_s2w26_count", got.size(), 169);
      chk("bp_hold_seen", (hold_cycles >= 5) ? 1 : 0, 1);
      chk("bp_done_once", done_cnt, 1);

      // abort with reset after 20 pixels, then a clean stride-1 frame
      make_src(1, 13);
      start_frame(2'd1, 13);
      feed(0, 20);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      make_src(2, 13);
      start_frame(2'd2, 13);
      feed(0, 169);
      wait_done(3000);
      build_exp(2, 13);
      check_stream("after_reset_s1w13_stream");
      chk("after_reset_count", got.size(), 169);
      chk("after_reset_done_once", done_cnt, 1);

      // start while busy is ignored
      make_src(0, 4);
      start_frame(2'd1, 4);
      feed(0, 6);
      cfg_mode  = 2'd0;
      cfg_width = WB'(6);
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      feed(6, 16);
      wait_done(200);
      build_exp(1, 4);
      check_stream("restart_ignored_stream");
      chk("restart_ignored_done_once", done_cnt, 1);
      chk("restart_ignored_idle", busy, 0);

      // out-of-range widths finish with no outputs
      for (int i = 0; i < 2; i++) begin
         start_frame(2'd1, bad_w[i]);
         wait_done(50);
         chk($sformatf("badw%0d_outputs", bad_w[i]), got.size(), 0);
         chk($sformatf("badw%0d_done_once", bad_w[i]), done_cnt, 1);
         chk($sformatf("badw%0d_done_latency", bad_w[i]), done_cyc - s_cyc, 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
